// File: rtl/ct_mat_exu_cfg_unit_v2.sv
// Matrix configuration unit: holds clamped sizeK/sizeM/sizeN, waits for in-flight
// matrix ops to drain before a size write, and returns an IID-tagged writeback.
module ct_mat_exu_cfg_unit_v2 #(
    parameter int                      SIZE_K_WIDTH = 16,
    parameter int                      SIZE_M_WIDTH = 8,
    parameter int                      SIZE_N_WIDTH = 8,
    parameter logic [SIZE_K_WIDTH-1:0] MAX_K        = 16'd256,
    parameter logic [SIZE_M_WIDTH-1:0] MAX_M        = 8'd16,
    parameter logic [SIZE_N_WIDTH-1:0] MAX_N        = 8'd16,
    parameter int                      IID_WIDTH    = 7
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    idu_mat_rf_cfg_vld,
    output logic                    mat_idu_rf_cfg_rdy,
    input  logic [3:0]              idu_mat_rf_cfg_op,
    input  logic [63:0]             idu_mat_rf_cfg_src0,
    input  logic [IID_WIDTH-1:0]    idu_mat_rf_cfg_iid,
    input  logic                    x_mat_inflight,
    input  logic                    rtu_yy_xx_flush,
    output logic                    mat_idu_cfg_wb_vld,
    input  logic                    idu_mat_cfg_wb_rdy,
    output logic [IID_WIDTH-1:0]    mat_idu_cfg_wb_iid,
    output logic [63:0]             mat_idu_cfg_wb_data,
    output logic                    mat_idu_cfg_wb_illegal,
    output logic [SIZE_K_WIDTH-1:0] x_sizeK,
    output logic [SIZE_M_WIDTH-1:0] x_sizeM,
    output logic [SIZE_N_WIDTH-1:0] x_sizeN,
    output logic [63:0]             mat_idu_cfg_sync_xmsize_csr,
    output logic                    mat_cfg_busy,
    output logic [1:0]              mat_cfg_state_dbg
);
    localparam int KW = SIZE_K_WIDTH;
    localparam int MW = SIZE_M_WIDTH;
    localparam int NW = SIZE_N_WIDTH;
    localparam int UW = KW + MW + NW;

    // Handshakes: a request moves on a clock edge where vld and rdy are both high;
    // the writeback is consumed on an edge where wb_vld and wb_rdy are both high.
    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, WB = 2'd2} state_e;

    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [MW-1:0]        m_q, m_d;
    logic [NW-1:0]        n_q, n_d;
    logic [3:0]           buf_op_q, buf_op_d;
    logic [UW-1:0]        buf_src_q, buf_src_d;
    logic [IID_WIDTH-1:0] buf_iid_q, buf_iid_d;
    logic                 wb_vld_q, wb_vld_d;
    logic [IID_WIDTH-1:0] wb_iid_q, wb_iid_d;
    logic [63:0]          wb_data_q, wb_data_d;
    logic                 wb_illegal_q, wb_illegal_d;

    logic [3:0]    sel_op;
    logic [UW-1:0] sel_src;
    logic          op_onehot, op_multi, accept, apply, load_wb;
    logic [KW-1:0] req_k;
    logic [MW-1:0] req_m;
    logic [NW-1:0] req_n;
    logic          unused_src;

    function automatic logic [63:0] pack_xmsize(input logic [KW-1:0] k,
                                                input logic [NW-1:0] n,
                                                input logic [MW-1:0] m);
        logic [63:0] x;
        x = '0;
        x[MW-1:0]      = m;
        x[MW +: NW]    = n;
        x[MW+NW +: KW] = k;
        return x;
    endfunction

    assign unused_src = ^idu_mat_rf_cfg_src0;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        m_d          = m_q;
        n_d          = n_q;
        buf_op_d     = buf_op_q;
        buf_src_d    = buf_src_q;
        buf_iid_d    = buf_iid_q;
        wb_vld_d     = wb_vld_q;
        wb_iid_d     = wb_iid_q;
        wb_data_d    = wb_data_q;
        wb_illegal_d = wb_illegal_q;
        apply        = 1'b0;
        load_wb      = 1'b0;

        accept    = (state_q == IDLE) && idu_mat_rf_cfg_vld && !rtu_yy_xx_flush;
        sel_op    = (state_q == DRAIN) ? buf_op_q  : idu_mat_rf_cfg_op;
        sel_src   = (state_q == DRAIN) ? buf_src_q : idu_mat_rf_cfg_src0[UW-1:0];
        op_onehot = (sel_op == 4'b0001) || (sel_op == 4'b0010) ||
                    (sel_op == 4'b0100) || (sel_op == 4'b1000);
        op_multi  = !op_onehot && (sel_op != 4'b0000);

        // ALL packs fields like xmsize; single-field ops take the operand LSBs.
        req_m = sel_src[MW-1:0];
        req_n = sel_op[3] ? sel_src[MW +: NW]    : sel_src[NW-1:0];
        req_k = sel_op[3] ? sel_src[MW+NW +: KW] : sel_src[KW-1:0];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_op_d  = idu_mat_rf_cfg_op;
                    buf_src_d = idu_mat_rf_cfg_src0[UW-1:0];
                    buf_iid_d = idu_mat_rf_cfg_iid;
                    if (x_mat_inflight && op_onehot) begin
                        state_d = DRAIN;
                    end else begin
                        apply        = op_onehot;
                        load_wb      = 1'b1;
                        wb_iid_d     = idu_mat_rf_cfg_iid;
                        wb_illegal_d = op_multi;
                    end
                end
            end
            DRAIN: begin
                if (rtu_yy_xx_flush) begin
                    state_d = IDLE;
                end else if (!x_mat_inflight) begin
                    apply        = 1'b1;
                    load_wb      = 1'b1;
                    wb_iid_d     = buf_iid_q;
                    wb_illegal_d = 1'b0;
                end
            end
            WB: begin
                if (rtu_yy_xx_flush || idu_mat_cfg_wb_rdy) begin
                    state_d  = IDLE;
                    wb_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (apply && (sel_op[0] || sel_op[3])) k_d = (req_k > MAX_K) ? MAX_K : req_k;
        if (apply && (sel_op[1] || sel_op[3])) m_d = (req_m > MAX_M) ? MAX_M : req_m;
        if (apply && (sel_op[2] || sel_op[3])) n_d = (req_n > MAX_N) ? MAX_N : req_n;

        if (load_wb) begin
            state_d   = WB;
            wb_vld_d  = 1'b1;
            wb_data_d = pack_xmsize(k_d, n_d, m_d);
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q      <= IDLE;
            k_q          <= '0;
            m_q          <= '0;
            n_q          <= '0;
            buf_op_q     <= '0;
            buf_src_q    <= '0;
            buf_iid_q    <= '0;
            wb_vld_q     <= 1'b0;
            wb_iid_q     <= '0;
            wb_data_q    <= '0;
            wb_illegal_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            m_q          <= m_d;
            n_q          <= n_d;
            buf_op_q     <= buf_op_d;
            buf_src_q    <= buf_src_d;
            buf_iid_q    <= buf_iid_d;
            wb_vld_q     <= wb_vld_d;
            wb_iid_q     <= wb_iid_d;
            wb_data_q    <= wb_data_d;
            wb_illegal_q <= wb_illegal_d;
        end
    end

    assign mat_idu_rf_cfg_rdy          = (state_q == IDLE) && !rtu_yy_xx_flush;
    assign mat_idu_cfg_wb_vld          = wb_vld_q;
    assign mat_idu_cfg_wb_iid          = wb_iid_q;
    assign mat_idu_cfg_wb_data         = wb_data_q;
    assign mat_idu_cfg_wb_illegal      = wb_illegal_q;
    assign x_sizeK                     = k_q;
    assign x_sizeM                     = m_q;
    assign x_sizeN                     = n_q;
    assign mat_idu_cfg_sync_xmsize_csr = pack_xmsize(k_q, n_q, m_q);
    assign mat_cfg_busy                = (state_q != IDLE);
    assign mat_cfg_state_dbg           = state_q;

endmodule

// File: tb/tb_ct_mat_exu_cfg_unit_v2.sv
// Directed bench for ct_mat_exu_cfg_unit_v2: inputs change on negedge, outputs
// are checked on negedge against hand-computed values.
module tb_ct_mat_exu_cfg_unit_v2;
    logic        clk;
    logic        rst_n;
    logic        vld;
    logic        rdy;
    logic [3:0]  op;
    logic [63:0] src0;
    logic [6:0]  iid;
    logic        inflight;
    logic        flush;
    logic        wb_vld;
    logic        wb_rdy;
    logic [6:0]  wb_iid;
    logic [63:0] wb_data;
    logic        wb_illegal;
    logic [15:0] size_k;
    logic [7:0]  size_m;
    logic [7:0]  size_n;
    logic [63:0] csr;
    logic        busy;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    ct_mat_exu_cfg_unit_v2 dut (
        .forever_cpuclk              (clk),
        .cpurst_b                    (rst_n),
        .idu_mat_rf_cfg_vld          (vld),
        .mat_idu_rf_cfg_rdy          (rdy),
        .idu_mat_rf_cfg_op           (op),
        .idu_mat_rf_cfg_src0         (src0),
        .idu_mat_rf_cfg_iid          (iid),
        .x_mat_inflight              (inflight),
        .rtu_yy_xx_flush             (flush),
        .mat_idu_cfg_wb_vld          (wb_vld),
        .idu_mat_cfg_wb_rdy          (wb_rdy),
        .mat_idu_cfg_wb_iid          (wb_iid),
        .mat_idu_cfg_wb_data         (wb_data),
        .mat_idu_cfg_wb_illegal      (wb_illegal),
        .x_sizeK                     (size_k),
        .x_sizeM                     (size_m),
        .x_sizeN                     (size_n),
        .mat_idu_cfg_sync_xmsize_csr (csr),
        .mat_cfg_busy                (busy),
        .mat_cfg_state_dbg           (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] o, input logic [63:0] s, input logic [6:0] id);
        @(negedge clk);
        vld  = 1'b1;
        op   = o;
        src0 = s;
        iid  = id;
        @(negedge clk);
        vld  = 1'b0;
    endtask

    task automatic ack();
        wb_rdy = 1'b1;
        @(negedge clk);
        wb_rdy = 1'b0;
        check("ack_busy", {63'd0, busy}, 64'd0);
        check("ack_wb_vld", {63'd0, wb_vld}, 64'd0);
    endtask

    task automatic check_sizes(input string tag, input logic [15:0] k,
                               input logic [7:0] n, input logic [7:0] m);
        check({tag, "_k"}, {48'd0, size_k}, {48'd0, k});
        check({tag, "_n"}, {56'd0, size_n}, {56'd0, n});
        check({tag, "_m"}, {56'd0, size_m}, {56'd0, m});
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; op = '0; src0 = '0; iid = '0;
        inflight = 1'b0; flush = 1'b0; wb_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_rdy", {63'd0, rdy}, 64'd1);
        check("rst_wb_vld", {63'd0, wb_vld}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_wb_iid", {57'd0, wb_iid}, 64'd0);
        check("rst_illegal", {63'd0, wb_illegal}, 64'd0);
        check("rst_csr", csr, 64'd0);
        check_sizes("rst", 16'd0, 8'd0, 8'd0);

        // ALL op, no drain: visible one cycle after accept
        send(4'b1000, 64'h0000_0000_0040_0808, 7'h15);
        check_sizes("all", 16'h0040, 8'h08, 8'h08);
        check("all_wb_vld", {63'd0, wb_vld}, 64'd1);
        check("all_wb_data", wb_data, 64'h0040_0808);
        check("all_csr", csr, 64'h0040_0808);
        check("all_wb_iid", {57'd0, wb_iid}, 64'h15);
        check("all_rdy", {63'd0, rdy}, 64'd0);
        check("all_state", {62'd0, state_dbg}, 64'd2);
        ack();
        check("all_rdy_after", {63'd0, rdy}, 64'd1);

        // Fresh state, then K field truncation and M clamp
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        send(4'b0001, 64'h0000_0000_0001_0000, 7'h21);
        check("k_trunc_wb_data", wb_data, 64'h0);
        check("k_trunc_k", {48'd0, size_k}, 64'h0);
        ack();
        send(4'b0010, 64'h20, 7'h22);
        check("m_clamp_m", {56'd0, size_m}, 64'h10);
        check("m_clamp_wb_data", wb_data, 64'h10);
        check("m_clamp_iid", {57'd0, wb_iid}, 64'h22);
        ack();

        // Multi-hot op is illegal and writes nothing
        send(4'b0011, 64'hffff, 7'h33);
        check("ill_flag", {63'd0, wb_illegal}, 64'd1);
        check("ill_wb_data", wb_data, 64'h10);
        check_sizes("ill", 16'd0, 8'd0, 8'h10);
        ack();

        // Read-only op never drains even with inflight high
        inflight = 1'b1;
        send(4'b0000, 64'h1234, 7'h34);
        check("ro_wb_vld", {63'd0, wb_vld}, 64'd1);
        check("ro_illegal", {63'd0, wb_illegal}, 64'd0);
        check("ro_wb_data", wb_data, 64'h10);
        ack();

        // N write held in DRAIN for 4 cycles of inflight
        send(4'b0100, 64'h5, 7'h44);
        check("drn_busy", {63'd0, busy}, 64'd1);
        check("drn_state", {62'd0, state_dbg}, 64'd1);
        check("drn_rdy", {63'd0, rdy}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drn_n_hold", {56'd0, size_n}, 64'h0);
            check("drn_no_wb", {63'd0, wb_vld}, 64'd0);
        end
        inflight = 1'b0;
        @(negedge clk);
        check("drn_n_new", {56'd0, size_n}, 64'h5);
        check("drn_wb_vld", {63'd0, wb_vld}, 64'd1);
        check("drn_wb_data", wb_data, 64'h0510);
        check("drn_wb_iid", {57'd0, wb_iid}, 64'h44);
        ack();

        // Flush in DRAIN drops the write; flush in IDLE blocks a request
        inflight = 1'b1;
        send(4'b0100, 64'h9, 7'h55);
        check("fl_busy_pre", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        check("fl_busy", {63'd0, busy}, 64'd0);
        check("fl_no_wb", {63'd0, wb_vld}, 64'd0);
        check("fl_n_keep", {56'd0, size_n}, 64'h5);
        check("fl_rdy_gated", {63'd0, rdy}, 64'd0);
        vld = 1'b1; op = 4'b0100; src0 = 64'h7; iid = 7'h56;
        @(negedge clk);
        check("fl_idle_no_accept", {63'd0, busy}, 64'd0);
        check("fl_idle_n", {56'd0, size_n}, 64'h5);
        vld = 1'b0; flush = 1'b0; inflight = 1'b0;
        #1;
        check("fl_rdy_back", {63'd0, rdy}, 64'd1);

        // ALL op with K and N above their maxima
        send(4'b1000, 64'h0000_0000_0fff_1103, 7'h66);
        check_sizes("clamp", 16'h0100, 8'h10, 8'h03);
        check("clamp_wb_data", wb_data, 64'h0100_1003);
        ack();
        send(4'b0010, 64'h0, 7'h67);
        check("zero_m", {56'd0, size_m}, 64'h0);
        check("zero_wb_data", wb_data, 64'h0100_1000);
        ack();

        // WB stalled by wb_rdy=0, then flushed
        send(4'b0100, 64'h3, 7'h77);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_wb_vld", {63'd0, wb_vld}, 64'd1);
            check("hold_wb_data", wb_data, 64'h0100_0300);
            check("hold_wb_iid", {57'd0, wb_iid}, 64'h77);
            check("hold_rdy", {63'd0, rdy}, 64'd0);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("wbfl_wb_vld", {63'd0, wb_vld}, 64'd0);
        check("wbfl_n_keep", {56'd0, size_n}, 64'h3);
        check("wbfl_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of DRAIN
        inflight = 1'b1;
        send(4'b0001, 64'h20, 7'h08);
        check("ar_busy_pre", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_sizes("ar", 16'd0, 8'd0, 8'd0);
        check("ar_busy", {63'd0, busy}, 64'd0);
        check("ar_rdy", {63'd0, rdy}, 64'd1);
        check("ar_wb_vld", {63'd0, wb_vld}, 64'd0);
        check("ar_wb_data", wb_data, 64'd0);
        check("ar_wb_iid", {57'd0, wb_iid}, 64'd0);
        check("ar_csr", csr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        inflight = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
